// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I core with one shared instruction/data memory.
// The FSM sequences PC, IR/OldPC, register file, ALU, ALUOut and Data registers. Each state
// drives its own control values. ImmSrc and ALUControl are decoded combinationally from the
// instruction fields. Every memory access waits for the memory-ready handshake.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp,
    output logic       Retire
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RALU = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_mem_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_retire;
    logic [1:0] w_alu_op;
    logic       w_r_sub;

    // Without a handshake the memory is treated as always completing in one cycle.
    assign w_mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

    // A subtract needs funct7b5 set, and only R-type (op[5]=1) may select it.
    // This keeps addi with an immediate bit 30 set as an add.
    assign w_r_sub = funct7b5 & op[5];

    // State register: reset aborts any instruction and parks the FSM in FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: memory states hold until the access completes.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (w_mem_ready) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW:   w_next_state = S_MEMADR;
                    OP_SW:   w_next_state = S_MEMADR;
                    OP_RALU: w_next_state = S_EXECUTER;
                    OP_IALU: w_next_state = S_EXECUTEI;
                    OP_BEQ:  w_next_state = S_BEQ;
                    OP_JAL:  w_next_state = S_JAL;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (w_mem_ready) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: begin
                if (w_mem_ready) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Per-state control values. An unlisted control stays at 0.
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_adr_src   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        w_alu_op    = 2'b00;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_ir_write  = w_mem_ready;
                w_pc_update = w_mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_RALU, OP_IALU, OP_BEQ, OP_JAL: w_illegal = 1'b0;
                    default:                                         w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = w_mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
                w_retire = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
                w_alu_op = 2'b00;
            end
        endcase
    end

    // Write-type strobes are suppressed while reset is held, so no state is disturbed.
    always_comb begin
        if (!reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
            Retire    = 1'b0;
        end else begin
            PCWrite   = w_pc_update | (w_branch & Zero);
            IRWrite   = w_ir_write;
            MemWrite  = w_mem_write;
            RegWrite  = w_reg_write;
            IllegalOp = w_illegal;
            Retire    = w_retire;
        end
    end

    assign AdrSrc = w_adr_src;

    // ALU decoder: ALUOp selects add, sub, or a funct3-driven operation.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (w_r_sub) begin
                            ALUControl = 3'b001;
                        end else begin
                            ALUControl = 3'b000;
                        end
                    end
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode alone.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW:   ImmSrc = 2'b00;
            OP_IALU: ImmSrc = 2'b00;
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for a multicycle RV32I core built on a single shared instruction/data memory.
- Sequences the multicycle datapath: PC, IR, OldPC, register file, ALU, ALUOut and Data registers.
- Decodes op/funct fields into Moore-style per-state control plus combinational ImmSrc/ALUControl.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal; waits on a memory-ready handshake for every memory access.

Parameters:
- MEM_HANDSHAKE, 1, when 1 the FSM honours MemReady; when 0 MemReady is internally forced to 1.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- op  input  7  Instr[6:0] from IR.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completed current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- RegWrite  output  1  register file write enable.
- ImmSrc  output  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- IllegalOp  output  1  one-cycle pulse in DECODE for an unsupported op.
- Retire  output  1  one-cycle pulse in the last state of each instruction.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. 4-bit state register.
- Reset: while reset=0, state=FETCH and PCWrite, IRWrite, MemWrite, RegWrite, IllegalOp and Retire are forced 0. Other outputs show FETCH decode.
- Reset asserted mid-instruction aborts it immediately. No write enable asserts during reset. After release, first edge starts FETCH.
- Transitions:
  - FETCH: to DECODE when MemReady, else hold.
  - DECODE: lw(0000011)/sw(0100011) to MEMADR; 0110011 to EXECUTER; 0010011 to EXECUTEI; 1100011 to BEQ; 1101111 to JAL; any other op to FETCH with IllegalOp=1.
  - MEMADR: lw to MEMREAD, sw to MEMWRITE.
  - MEMREAD: to MEMWB on MemReady. MEMWB to FETCH.
  - MEMWRITE: to FETCH on MemReady.
  - EXECUTER and EXECUTEI: to ALUWB. ALUWB to FETCH.
  - BEQ: to FETCH. JAL: to ALUWB.
- Per-state outputs (unlisted = 0; ALUOp internal, 2 bits):
  - FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady, Retire=MemReady.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, Retire=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero).
- ALU decoder:
  - ALUOp 00 gives add. ALUOp 01 gives sub.
  - ALUOp 10 by funct3: 000 gives sub if funct7b5 & op[5], else add; 010 gives slt; 110 gives or; 111 gives and; others give add.
- ImmSrc is combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
- Cycle counts with MemReady always 1:
  - lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MEMWRITE: MemWrite stays high through the stall and drops on the cycle after MemReady.

Test Plan:
- Reset low with op=0110011 -> PCWrite, IRWrite, RegWrite, MemWrite all 0. After release: FETCH, with IRWrite=1 and PCWrite=1 on the first cycle.
- lw (op=0000011), MemReady=1 -> states 0,1,2,3,4. ALUControl=000 in MEMADR. RegWrite=1 and ResultSrc=01 only in MEMWB. Retire pulses once.
- sw (op=0100011), MemReady low for 2 MEMWRITE cycles -> MemWrite=1 for 3 cycles, AdrSrc=1. Return to FETCH. ImmSrc=01.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER, ALUWB RegWrite=1.
- I-type addi with funct7b5=1 -> ALUControl=000 (op[5]=0).
- beq with Zero=1 -> PCWrite=1 in BEQ. With Zero=0 -> PCWrite=0. Both take 3 cycles.
- jal -> states 0,1,10,8, PCWrite=1 in JAL.
- Illegal op 1110011 -> IllegalOp=1 in DECODE, then FETCH, with no RegWrite or MemWrite.
- Reset asserted during MEMREAD -> state returns to FETCH asynchronously with no RegWrite.
